cmos_window_crop: RTL and testbench

Parametrised crop-and-decimate stage on the camera pixel stream, clocked by `cam_pclk`, between the CMOS capture block and the DDR3 write FIFO. It keeps a configurable rectangular window of each frame, optionally decimates it by 1/2/4 per axis, and tags the output stream with frame and line markers. It reports the resulting frame geometry and the DDR3 address span. Window configuration is double-buffered and applied only at frame boundaries, so a frame is never cropped with mixed settings.

---
 rtl/cmos_window_crop.sv | 197 +++++++++++++++++++
 tb/tb_cmos_window_crop.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_window_crop.sv
// Crop-and-decimate stage on the camera pixel stream: keeps a double-buffered rectangular
// window of each frame, optionally decimated per axis, and tags frame/line boundaries.
module cmos_window_crop #(
    parameter int DATA_W = 16,
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 480,
    parameter int CNT_W  = 11
) (
    input  logic                 cam_pclk,
    input  logic                 rst_n,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic                 cam_data_valid,
    input  logic [DATA_W-1:0]    cam_data,
    input  logic                 cfg_wr,
    input  logic [CNT_W-1:0]     cfg_left,
    input  logic [CNT_W-1:0]     cfg_right,
    input  logic [CNT_W-1:0]     cfg_top,
    input  logic [CNT_W-1:0]     cfg_bottom,
    input  logic [1:0]           cfg_hdec,
    input  logic [1:0]           cfg_vdec,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic [CNT_W-1:0]     h_pixel,
    output logic [CNT_W-1:0]     v_pixel,
    output logic [2*CNT_W-1:0]   ddr3_addr_max,
    output logic                 cfg_pending,
    output logic                 cfg_err
);

    typedef struct packed {
        logic [CNT_W-1:0] left;
        logic [CNT_W-1:0] right;
        logic [CNT_W-1:0] top;
        logic [CNT_W-1:0] bottom;
        logic [1:0]       hdec;
        logic [1:0]       vdec;
    } win_t;

    localparam win_t WIN_RST = '{left: '0, right: CNT_W'(MAX_W), top: '0,
                                 bottom: CNT_W'(MAX_H), hdec: 2'd0, vdec: 2'd0};

    // Decimation code 3 is stored as 2, so everything downstream sees only 0..2.
    function automatic logic [1:0] norm_dec(input logic [1:0] d);
        return (d == 2'd3) ? 2'd2 : d;
    endfunction

    function automatic logic [1:0] dec_mask(input logic [1:0] d);
        return (d == 2'd0) ? 2'b00 : (d == 2'd1) ? 2'b01 : 2'b11;
    endfunction

    logic vs_d0, vs_d1, hr_d0, hr_d1;
    logic fs, le;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    win_t act_win, pend_win, wr_win;
    logic wr_ok;

    assign fs = vs_d0 & ~vs_d1;
    assign le = ~hr_d0 & hr_d1;

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0 <= 1'b0;
            vs_d1 <= 1'b0;
            hr_d0 <= 1'b0;
            hr_d1 <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            vs_d0 <= cam_vsync;
            vs_d1 <= vs_d0;
            hr_d0 <= cam_href;
            hr_d1 <= hr_d0;
            if (fs || le)
                h_cnt <= '0;
            else if (cam_data_valid)
                h_cnt <= h_cnt + 1'b1;
            if (fs)
                v_cnt <= '0;
            else if (le)
                v_cnt <= v_cnt + 1'b1;
        end
    end

    assign wr_win = '{left: cfg_left, right: cfg_right, top: cfg_top, bottom: cfg_bottom,
                      hdec: norm_dec(cfg_hdec), vdec: norm_dec(cfg_vdec)};
    assign wr_ok  = (cfg_left < cfg_right) && (cfg_right <= CNT_W'(MAX_W)) &&
                    (cfg_top < cfg_bottom) && (cfg_bottom <= CNT_W'(MAX_H));

    // A write coinciding with FS lands in pending after the old pending was promoted.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            act_win     <= WIN_RST;
            pend_win    <= WIN_RST;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (fs && cfg_pending) begin
                act_win     <= pend_win;
                cfg_pending <= 1'b0;
            end
            if (cfg_wr) begin
                if (wr_ok) begin
                    pend_win    <= wr_win;
                    cfg_pending <= 1'b1;
                    cfg_err     <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    logic [CNT_W-1:0] hmask, vmask, h_off, v_off;
    logic [CNT_W:0]   h_span, v_span, h_shift, v_shift;
    logic             in_win, keep, emit, last_col, last_row;
    logic [CNT_W-1:0] oc, orow;
    logic             armed, done;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        hmask    = {{(CNT_W-2){1'b0}}, dec_mask(act_win.hdec)};
        vmask    = {{(CNT_W-2){1'b0}}, dec_mask(act_win.vdec)};
        h_span   = {1'b0, act_win.right} - {1'b0, act_win.left} + {1'b0, hmask};
        v_span   = {1'b0, act_win.bottom} - {1'b0, act_win.top} + {1'b0, vmask};
        h_shift  = h_span >> act_win.hdec;
        v_shift  = v_span >> act_win.vdec;
        h_off    = h_cnt - act_win.left;
        v_off    = v_cnt - act_win.top;
        in_win   = (h_cnt >= act_win.left) && (h_cnt < act_win.right) &&
                   (v_cnt >= act_win.top) && (v_cnt < act_win.bottom);
        keep     = cam_data_valid && in_win &&
                   ((h_off & hmask) == '0) && ((v_off & vmask) == '0);
        emit     = keep && armed && !done && !fs && !le;
        last_col = (oc == h_pixel - CNT_W'(1));
        last_row = (orow == v_pixel - CNT_W'(1));
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_pixel       <= CNT_W'(MAX_W);
            v_pixel       <= CNT_W'(MAX_H);
            ddr3_addr_max <= (2*CNT_W)'(MAX_W * MAX_H);
        end else begin
            h_pixel       <= h_shift[CNT_W-1:0];
            v_pixel       <= v_shift[CNT_W-1:0];
            ddr3_addr_max <= {{CNT_W{1'b0}}, h_pixel} * {{CNT_W{1'b0}}, v_pixel};
        end
    end

    // armed stays low after reset until a full frame start, so partial frames stay silent.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            oc        <= '0;
            orow      <= '0;
            armed     <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (fs) begin
                oc    <= '0;
                orow  <= '0;
                armed <= 1'b1;
                done  <= 1'b0;
            end else if (le) begin
                oc <= '0;
                if (oc != '0)
                    orow <= orow + 1'b1;
            end else if (emit) begin
                if (last_col) begin
                    oc   <= '0;
                    orow <= orow + 1'b1;
                    if (last_row)
                        done <= 1'b1;
                end else begin
                    oc <= oc + 1'b1;
                end
            end
            out_valid <= emit;
            if (emit)
                out_data <= cam_data;
            out_sof <= emit && (oc == '0) && (orow == '0);
            out_eol <= emit && last_col;
            out_eof <= emit && last_col && last_row;
        end
    end

endmodule

// File: tb/tb_cmos_window_crop.sv
// Directed bench for cmos_window_crop on a reduced 16x12 sensor; kept pixels are predicted
// from the window rules into a scoreboard queue and compared as the DUT emits them.
module tb_cmos_window_crop;

    localparam int DATA_W = 16;
    localparam int MAX_W  = 16;
    localparam int MAX_H  = 12;
    localparam int CNT_W  = 5;

    logic                cam_pclk = 1'b0;
    logic                rst_n;
    logic                cam_vsync, cam_href, cam_data_valid;
    logic [DATA_W-1:0]   cam_data;
    logic                cfg_wr;
    logic [CNT_W-1:0]    cfg_left, cfg_right, cfg_top, cfg_bottom;
    logic [1:0]          cfg_hdec, cfg_vdec;
    logic                out_valid, out_sof, out_eol, out_eof;
    logic [DATA_W-1:0]   out_data;
    logic [CNT_W-1:0]    h_pixel, v_pixel;
    logic [2*CNT_W-1:0]  ddr3_addr_max;
    logic                cfg_pending, cfg_err;

    cmos_window_crop #(.DATA_W(DATA_W), .MAX_W(MAX_W), .MAX_H(MAX_H), .CNT_W(CNT_W)) dut (
        .cam_pclk(cam_pclk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data_valid(cam_data_valid), .cam_data(cam_data), .cfg_wr(cfg_wr),
        .cfg_left(cfg_left), .cfg_right(cfg_right), .cfg_top(cfg_top), .cfg_bottom(cfg_bottom),
        .cfg_hdec(cfg_hdec), .cfg_vdec(cfg_vdec), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .h_pixel(h_pixel),
        .v_pixel(v_pixel), .ddr3_addr_max(ddr3_addr_max), .cfg_pending(cfg_pending),
        .cfg_err(cfg_err)
    );

    always #5 cam_pclk = ~cam_pclk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    logic [DATA_W+2:0] sb[$];
    logic [DATA_W-1:0] last_exp_data = '0;

    // Window model: index 0..5 = left, right, top, bottom, hdec, vdec.
    int w[6];
    int m_act[6];
    int m_pnd[6];
    bit m_pending = 1'b0;
    bit m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    always @(negedge cam_pclk) begin
        if (rst_n && out_valid) begin
            n_valid++;
            check("sb_has_entry", (sb.size() > 0), 1);
            if (sb.size() > 0)
                check("pixel_data_markers", {out_data, out_sof, out_eol, out_eof}, sb.pop_front());
        end
        if (rst_n && !out_valid && (out_sof || out_eol || out_eof))
            check("stray_marker", {out_sof, out_eol, out_eof}, 0);
    end

    task automatic set_w(input int l, input int r, input int t, input int b,
                         input int hd, input int vd);
        w = '{l, r, t, b, hd, vd};
        cfg_left   = CNT_W'(l);
        cfg_right  = CNT_W'(r);
        cfg_top    = CNT_W'(t);
        cfg_bottom = CNT_W'(b);
        cfg_hdec   = 2'(hd);
        cfg_vdec   = 2'(vd);
    endtask

    task automatic model_write();
        if (w[0] < w[1] && w[1] <= MAX_W && w[2] < w[3] && w[3] <= MAX_H) begin
            m_pnd = w;
            if (m_pnd[4] == 3) m_pnd[4] = 2;
            if (m_pnd[5] == 3) m_pnd[5] = 2;
            m_pending = 1'b1;
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic write_cfg();
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        model_write();
    endtask

    // One frame of `lines` lines; optional config write after line wr_line or at FS.
    task automatic run_frame(input int lines, input int exp_cnt, input int wr_line, input bit wr_fs);
        int hm, vm, eh, ev, lh, lv;
        bit k, sof, eol, eof;
        n_valid = 0;
        cam_vsync = 1'b1;
        tick();
        if (wr_fs) cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        if (m_pending) begin
            m_act = m_pnd;
            m_pending = 1'b0;
        end
        if (wr_fs) model_write();
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
        hm = (1 << m_act[4]) - 1;
        vm = (1 << m_act[5]) - 1;
        eh = (m_act[1] - m_act[0] + hm) >> m_act[4];
        ev = (m_act[3] - m_act[2] + vm) >> m_act[5];
        lh = m_act[0] + (((m_act[1] - m_act[0] - 1) >> m_act[4]) << m_act[4]);
        lv = m_act[2] + (((m_act[3] - m_act[2] - 1) >> m_act[5]) << m_act[5]);
        check("h_pixel", h_pixel, eh);
        check("v_pixel", v_pixel, ev);
        check("ddr3_addr_max", ddr3_addr_max, eh * ev);
        check("cfg_pending_after_fs", cfg_pending, m_pending);
        for (int v = 0; v < lines; v++) begin
            cam_href = 1'b1;
            for (int h = 0; h < MAX_W; h++) begin
                cam_data_valid = 1'b1;
                cam_data = DATA_W'(v * 256 + h);
                k = (h >= m_act[0]) && (h < m_act[1]) && (v >= m_act[2]) && (v < m_act[3]) &&
                    (((h - m_act[0]) & hm) == 0) && (((v - m_act[2]) & vm) == 0);
                if (k) begin
                    sof = (h == m_act[0]) && (v == m_act[2]);
                    eol = (h == lh);
                    eof = eol && (v == lv);
                    sb.push_back({cam_data, sof, eol, eof});
                    last_exp_data = cam_data;
                end
                tick();
            end
            cam_data_valid = 1'b0;
            cam_href = 1'b0;
            repeat (4) tick();
            if (v == wr_line) write_cfg();
        end
        repeat (3) tick();
        check("frame_pixel_count", n_valid, exp_cnt);
        check("sb_drained", sb.size(), 0);
        check("out_valid_idle", out_valid, 0);
        if (exp_cnt > 0) check("out_data_hold", out_data, last_exp_data);
    endtask

    initial begin
        m_act = '{0, MAX_W, 0, MAX_H, 0, 0};
        m_pnd = m_act;
        rst_n = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_data_valid = 1'b0;
        cam_data = '0;
        cfg_wr = 1'b0;
        set_w(0, MAX_W, 0, MAX_H, 0, 0);
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_out_data", out_data, 0);
        check("rst_h_pixel", h_pixel, MAX_W);
        check("rst_v_pixel", v_pixel, MAX_H);
        check("rst_ddr3_addr_max", ddr3_addr_max, MAX_W * MAX_H);
        check("rst_cfg_pending", cfg_pending, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        // Default full-frame pass-through.
        run_frame(MAX_H, MAX_W * MAX_H, -1, 1'b0);
        check("ddr_default", ddr3_addr_max, 192);

        // Mid-frame write leaves the current frame untouched.
        set_w(3, 11, 2, 8, 0, 0);
        run_frame(MAX_H, MAX_W * MAX_H, 5, 1'b0);
        check("pending_mid_frame", cfg_pending, 1);
        run_frame(MAX_H, 48, -1, 1'b0);
        check("crop_h_pixel", h_pixel, 8);
        check("crop_v_pixel", v_pixel, 6);

        // Same window decimated by 2 horizontally, 4 vertically.
        set_w(3, 11, 2, 8, 1, 2);
        write_cfg();
        check("pending_dec", cfg_pending, 1);
        run_frame(MAX_H, 8, -1, 1'b0);
        check("dec_h_pixel", h_pixel, 4);
        check("dec_v_pixel", v_pixel, 2);

        // Odd-width window with hdec=1.
        set_w(1, 6, 0, 3, 1, 0);
        write_cfg();
        run_frame(MAX_H, 9, -1, 1'b0);
        check("odd_h_pixel", h_pixel, 3);

        // Invalid write is rejected; active window persists across FS.
        set_w(10, 4, 0, 3, 0, 0);
        write_cfg();
        check("invalid_err", cfg_err, 1);
        check("invalid_pending", cfg_pending, 0);
        run_frame(MAX_H, 9, -1, 1'b0);
        check("invalid_err_sticky", cfg_err, m_err);
        set_w(2, 10, 1, 5, 0, 0);
        write_cfg();
        check("valid_clears_err", cfg_err, 0);
        check("valid_sets_pending", cfg_pending, 1);

        // Write coincident with FS: old pending now, new write next frame.
        set_w(4, 12, 3, 9, 1, 1);
        run_frame(MAX_H, 32, -1, 1'b1);
        check("coincident_pending", cfg_pending, 1);
        run_frame(MAX_H, 12, -1, 1'b0);
        check("coincident_h_pixel", h_pixel, 4);
        check("coincident_v_pixel", v_pixel, 3);
        check("coincident_pending_clear", cfg_pending, 0);

        // Short frame: only row 3 of the window arrives, no eof, then a clean full frame.
        run_frame(4, 4, -1, 1'b0);
        run_frame(MAX_H, 12, -1, 1'b0);

        // Reset asserted mid-line; nothing may be emitted until the next frame start.
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
        set_w(0, 8, 0, 4, 0, 0);
        write_cfg();
        set_w(9, 2, 0, 4, 0, 0);
        write_cfg();
        n_valid = 0;
        for (int v = 0; v < MAX_H; v++) begin
            cam_href = 1'b1;
            for (int h = 0; h < MAX_W; h++) begin
                cam_data_valid = 1'b1;
                cam_data = DATA_W'(v * 256 + h);
                if (v == 2 && h == 6) begin
                    rst_n = 1'b0;
                    #1;
                    check("midrst_out_valid", out_valid, 0);
                    check("midrst_cfg_pending", cfg_pending, 0);
                    check("midrst_cfg_err", cfg_err, 0);
                    check("midrst_h_pixel", h_pixel, MAX_W);
                end
                if (v == 2 && h == 8) rst_n = 1'b1;
                tick();
            end
            cam_data_valid = 1'b0;
            cam_href = 1'b0;
            repeat (4) tick();
        end
        check("post_reset_silent", n_valid, 0);
        check("post_reset_ddr", ddr3_addr_max, MAX_W * MAX_H);
        m_act = '{0, MAX_W, 0, MAX_H, 0, 0};
        m_pnd = m_act;
        m_pending = 1'b0;
        m_err = 1'b0;
        run_frame(MAX_H, MAX_W * MAX_H, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
